// File: rtl/button_bounce_gen.sv
// Synthetic push-button source: emits a pseudo-random bouncing press, a stable hold,
// a bouncing release and an idle gap on each start request, to exercise a debouncer.
module button_bounce_gen #(
  parameter int unsigned CLK_FREQ_HZ      = 10_000_000,
  parameter bit          IS_PULLUP        = 1'b0,
  parameter int unsigned BOUNCE_COUNT     = 4,
  parameter int unsigned BOUNCE_MASK_BITS = 10,
  parameter int unsigned HOLD_CYCLES      = 2_000_000,
  parameter int unsigned GAP_CYCLES       = 1_000_000,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       push_button,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_count
);

  localparam int unsigned TOGGLES      = 2 * BOUNCE_COUNT + 1;
  localparam int unsigned TW           = $clog2(TOGGLES + 1);
  localparam int unsigned MAX_INTERVAL = 1 << BOUNCE_MASK_BITS;
  localparam int unsigned MAX_PHASE    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_LOAD     = (MAX_PHASE > MAX_INTERVAL) ? MAX_PHASE : MAX_INTERVAL;
  localparam int unsigned CW           = $clog2(MAX_LOAD + 1);
  localparam logic        IDLE_LEVEL   = IS_PULLUP;
  localparam logic [15:0] SEED         = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  // The clock frequency is informational; nothing in the timing scales with it.
  if (CLK_FREQ_HZ == 0) begin : g_freq_unspecified
  end

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    GAP
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   lfsr, lfsr_nx, lfsr_adv;
  logic [CW-1:0] cnt, cnt_nx, interval;
  logic [TW-1:0] tog, tog_nx;
  logic          line_nx, busy_nx, done_nx;
  logic [7:0]    count_nx;
  logic          feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_adv = {lfsr[14:0], feedback};
  assign interval = CW'(lfsr[BOUNCE_MASK_BITS-1:0]) + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      cnt         <= '0;
      tog         <= '0;
      push_button <= IDLE_LEVEL;
      busy        <= 1'b0;
      done        <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_nx;
      lfsr        <= lfsr_nx;
      cnt         <= cnt_nx;
      tog         <= tog_nx;
      push_button <= line_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      press_count <= count_nx;
    end
  end

  // Each toggle except the last of a burst loads a fresh interval and steps the LFSR.
  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    cnt_nx   = cnt;
    tog_nx   = tog;
    line_nx  = push_button;
    busy_nx  = busy;
    done_nx  = 1'b0;
    count_nx = press_count;

    case (state)
      IDLE: begin
        // A start seen while done is still showing belongs to the finished sequence.
        if (start && !done) begin
          state_nx = PRESS_BOUNCE;
          line_nx  = ~IDLE_LEVEL;
          busy_nx  = 1'b1;
          tog_nx   = TW'(1);
          cnt_nx   = interval;
          lfsr_nx  = lfsr_adv;
        end
      end

      PRESS_BOUNCE, RELEASE_BOUNCE: begin
        if (cnt == CW'(1)) begin
          line_nx = ~push_button;
          tog_nx  = tog + TW'(1);
          if (tog_nx == TW'(TOGGLES)) begin
            if (state == PRESS_BOUNCE) begin
              state_nx = HOLD;
              cnt_nx   = CW'(HOLD_CYCLES);
            end else begin
              state_nx = GAP;
              cnt_nx   = CW'(GAP_CYCLES);
            end
          end else begin
            cnt_nx  = interval;
            lfsr_nx = lfsr_adv;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      HOLD: begin
        if (cnt == CW'(1)) begin
          state_nx = RELEASE_BOUNCE;
          line_nx  = IDLE_LEVEL;
          tog_nx   = TW'(1);
          cnt_nx   = interval;
          lfsr_nx  = lfsr_adv;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      GAP: begin
        if (cnt == CW'(1)) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          count_nx = press_count + 8'd1;
          tog_nx   = '0;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        line_nx  = IDLE_LEVEL;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: a pull-down and a pull-up instance share stimulus and are
// compared every cycle against a waveform model built from toggle times.
module tb_button_bounce_gen;

  localparam int          BC   = 2;
  localparam int          MB   = 3;
  localparam int          HC   = 20;
  localparam int          GC   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       line0, busy0, done0, line1, busy1, done1;
  logic [7:0] count0, count1;

  int total = 0;
  int bad = 0;

  logic        mActive = 1'b0;
  logic        mLine = 1'b0;
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [7:0]  mCount = 8'd0;
  logic [15:0] mLfsr = SEED;
  int          mK = 0;
  int          mLen = 0;
  int          mHoldStart = 0;
  int          mTog[$];

  int   edgeCount = 0;
  int   doneCount = 0;
  logic prevLine0 = 1'b0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       line;
    logic       busy;
    logic       done;
    logic [7:0] count;
  } vec_t;
  vec_t vecs[20];

  button_bounce_gen #(
    .CLK_FREQ_HZ(10_000_000), .IS_PULLUP(1'b0), .BOUNCE_COUNT(BC),
    .BOUNCE_MASK_BITS(MB), .HOLD_CYCLES(HC), .GAP_CYCLES(GC), .LFSR_SEED(SEED)
  ) u_pd (
    .clk(clk), .rst(rst), .start(start), .push_button(line0),
    .busy(busy0), .done(done0), .press_count(count0)
  );

  button_bounce_gen #(
    .CLK_FREQ_HZ(10_000_000), .IS_PULLUP(1'b1), .BOUNCE_COUNT(BC),
    .BOUNCE_MASK_BITS(MB), .HOLD_CYCLES(HC), .GAP_CYCLES(GC), .LFSR_SEED(SEED)
  ) u_pu (
    .clk(clk), .rst(rst), .start(start), .push_button(line1),
    .busy(busy1), .done(done1), .press_count(count1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Logical pressed level at cycle k is the parity of toggles that have happened by then.
  function automatic logic levelAt(input int k);
    int n = 0;
    foreach (mTog[i]) if (mTog[i] <= k) n++;
    return n[0];
  endfunction

  task automatic buildSequence();
    int t = 0;
    mTog.delete();
    mTog.push_back(0);
    for (int i = 0; i < 2 * BC; i++) begin
      t += int'(mLfsr[MB-1:0]) + 1;
      mLfsr = lfsrStep(mLfsr);
      mTog.push_back(t);
    end
    mHoldStart = t;
    t += HC;
    mTog.push_back(t);
    for (int i = 0; i < 2 * BC; i++) begin
      t += int'(mLfsr[MB-1:0]) + 1;
      mLfsr = lfsrStep(mLfsr);
      mTog.push_back(t);
    end
    mLen = t + GC;
  endtask

  task automatic modelStep();
    logic prevDone;
    prevDone = mDone;
    if (rst) begin
      mActive = 1'b0; mLine = 1'b0; mBusy = 1'b0; mDone = 1'b0;
      mCount = 8'd0; mLfsr = SEED;
    end else begin
      mDone = 1'b0;
      if (mActive) begin
        mK++;
        if (mK == mLen) begin
          mActive = 1'b0; mBusy = 1'b0; mDone = 1'b1; mLine = 1'b0;
          mCount = mCount + 8'd1;
        end else begin
          mLine = levelAt(mK);
        end
      end else if (start && !prevDone) begin
        buildSequence();
        mActive = 1'b1; mK = 0; mBusy = 1'b1; mLine = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs only change between negedges, so the model replays the edge just taken.
  task automatic tick();
    @(negedge clk);
    modelStep();
    if (line0 !== prevLine0) edgeCount++;
    prevLine0 = line0;
    if (done0 === 1'b1) doneCount++;
    if (bad < 50)
      checkOutput("model", {line0, line1, busy0, busy1, done0, done1, count0, count1},
                  {mLine, ~mLine, mBusy, mBusy, mDone, mDone, mCount, mCount});
  endtask

  task automatic applyStimulus(input logic r, input logic s);
    rst = r;
    start = s;
    tick();
  endtask

  task automatic waitDone(input int bound, output bit ok);
    int n = 0;
    while (done0 !== 1'b1 && n < bound) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    ok = (done0 === 1'b1);
    checkOutput("done_seen", {31'd0, done0}, 32'd1);
  endtask

  task automatic waitHold();
    int n = 0;
    while (!(mActive && mK == mHoldStart + 5) && n < 300) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("hold_line", {31'd0, line0}, 32'd1);
  endtask

  initial begin
    int baseEdges, baseDones;
    bit ok;

    // Seed ACE1 gives press intervals 2,4,8,8: toggles at k=0,2,6,14,22.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    for (int i = 6; i <= 9; i++)   vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    for (int i = 10; i <= 17; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};

    baseEdges = 0;
    baseDones = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        baseEdges = edgeCount;
        baseDones = doneCount;
      end
      applyStimulus(vecs[i].rst, vecs[i].start);
      checkOutput($sformatf("vec%0d", i), {line0, line1, busy0, done0, count0},
                  {vecs[i].line, ~vecs[i].line, vecs[i].busy, vecs[i].done, vecs[i].count});
    end
    waitDone(500, ok);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_count", {24'd0, count0}, 32'd1);
    checkOutput("single_edges", edgeCount - baseEdges, 32'd10);
    checkOutput("single_dones", doneCount - baseDones, 32'd1);

    $display("[TB] start while busy");
    baseEdges = edgeCount;
    baseDones = doneCount;
    applyStimulus(1'b0, 1'b1);
    waitHold();
    applyStimulus(1'b0, 1'b1);
    waitDone(500, ok);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("busy_ignored_busy", {31'd0, busy0}, 32'd0);
    checkOutput("busy_ignored_count", {24'd0, count0}, 32'd2);
    checkOutput("busy_ignored_edges", edgeCount - baseEdges, 32'd10);
    checkOutput("busy_ignored_dones", doneCount - baseDones, 32'd1);

    $display("[TB] back to back");
    baseEdges = edgeCount;
    baseDones = doneCount;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      waitDone(500, ok);
      if (i < 2) begin
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
      end
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_count", {24'd0, count0}, 32'd5);
    checkOutput("b2b_edges", edgeCount - baseEdges, 32'd30);
    checkOutput("b2b_dones", doneCount - baseDones, 32'd3);

    $display("[TB] reset during hold");
    applyStimulus(1'b0, 1'b1);
    waitHold();
    baseDones = doneCount;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_hold_outputs", {line0, line1, busy0, done0, count0}, {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_hold_nodone", doneCount - baseDones, 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reseed_k0", {31'd0, line0}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reseed_k1", {31'd0, line0}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reseed_k2", {31'd0, line0}, 32'd0);
    waitDone(500, ok);
    checkOutput("reseed_count", {24'd0, count0}, 32'd1);

    $display("[TB] random stimulus");
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 9) == 0);

    $display("[TB] pull-up idle and count wrap");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("pullup_idle", {30'd0, line1, line0}, 32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pullup_pressed", {30'd0, line1, line0}, 32'd1);
    for (int n = 1; n <= 256; n++) begin
      waitDone(500, ok);
      if (!ok) break;
      if (n == 255) checkOutput("count_255", {16'd0, count0, count1}, 32'h0000FFFF);
      if (n < 256) begin
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
      end
    end
    checkOutput("count_wrap", {16'd0, count0, count1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
